// File: rtl/payment_pkg.sv
// Shared definitions for the payment verification arbiter: FSM encoding,
// requester indices, default verifier timeout and a one-hot decode helper.
package payment_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NUM_REQ         = 4;
  localparam int CHEQUE          = 0;
  localparam int DD              = 1;
  localparam int CARD            = 2;
  localparam int CURRENCY        = 3;
  localparam int DEFAULT_TIMEOUT = 16;

  // Index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin selector. The search starts at the bit after the
// previous winner; the pointer only moves when the caller commits a grant.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       update,
  output logic [3:0] grant
);
  import payment_pkg::*;

  logic [1:0] r_ptr;
  logic [1:0] w_idx;
  logic       w_found;

  // Pick the first requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    grant   = 4'b0000;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  // Advance the pointer past the committed winner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= 2'd0;
    end else if (update && (|grant)) begin
      r_ptr <= onehot_to_idx(grant) + 2'd1;
    end
  end

endmodule

// File: rtl/payment_verify_arbiter.sv
// Arbitrates four payment instruments onto one shared verifier and keeps
// the outstanding bill balance. Accepted instruments reduce the balance,
// saturating at zero; a silent verifier times out and releases the slot.
module payment_verify_arbiter #(
  parameter int TIMEOUT = payment_pkg::DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bill_load,
  input  logic [7:0]  bill_value,
  input  logic [3:0]  req,
  input  logic [31:0] req_amount,
  output logic        v_req,
  output logic [1:0]  v_src,
  output logic [7:0]  v_amount,
  input  logic        v_ack,
  input  logic        v_ok,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        accepted,
  output logic [7:0]  remaining_amount,
  output logic        payment_complete,
  output logic        line_disconnected
);
  import payment_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic [1:0]    r_winner;
  logic [CW-1:0] r_cnt;
  logic          r_ok;
  logic          r_v_req;
  logic [1:0]    r_v_src;
  logic [7:0]    r_v_amount;
  logic [3:0]    r_grant;
  logic [3:0]    r_done;
  logic          r_accepted;
  logic [7:0]    r_rem;
  logic          r_loaded;
  logic          r_line_disc;

  logic [3:0]    w_rr_grant;
  logic          w_rr_update;
  logic [CW-1:0] w_cnt_inc;
  logic [7:0]    w_rem_sub;
  logic [7:0]    w_amt [NUM_REQ];

  // Split the packed amount bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_amt
      assign w_amt[gi] = req_amount[8*gi+7 -: 8];
    end
  endgenerate

  // A pending load takes priority, so arbitration waits a cycle behind it.
  assign w_rr_update = (r_state == IDLE) && !bill_load && (|req) && (r_rem != 8'd0);
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_rem_sub   = (r_rem > r_v_amount) ? (r_rem - r_v_amount) : 8'd0;

  rr_arbiter4 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (w_rr_update),
    .grant  (w_rr_grant)
  );

  // Transaction FSM with registered outputs; done/accepted/line pulses self-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_winner    <= 2'd0;
      r_cnt       <= '0;
      r_ok        <= 1'b0;
      r_v_req     <= 1'b0;
      r_v_src     <= 2'd0;
      r_v_amount  <= 8'd0;
      r_grant     <= 4'b0000;
      r_done      <= 4'b0000;
      r_accepted  <= 1'b0;
      r_rem       <= 8'd0;
      r_loaded    <= 1'b0;
      r_line_disc <= 1'b0;
    end else begin
      r_done      <= 4'b0000;
      r_accepted  <= 1'b0;
      r_line_disc <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bill_load) begin
            r_rem    <= bill_value;
            r_loaded <= 1'b1;
          end else if (w_rr_update) begin
            r_winner <= onehot_to_idx(w_rr_grant);
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_grant    <= 4'b0001 << r_winner;
          r_v_src    <= r_winner;
          r_v_amount <= w_amt[r_winner];
          r_v_req    <= 1'b1;
          r_cnt      <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (v_ack) begin
            r_ok    <= v_ok;
            r_v_req <= 1'b0;
            r_state <= RESP;
          end else if (w_cnt_inc == CW'(TIMEOUT)) begin
            r_cnt       <= '0;
            r_line_disc <= 1'b1;
            r_done      <= r_grant;
            r_grant     <= 4'b0000;
            r_v_req     <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RESP: begin
          r_done     <= r_grant;
          r_accepted <= r_ok;
          if (r_ok) r_rem <= w_rem_sub;
          r_grant    <= 4'b0000;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign v_req             = r_v_req;
  assign v_src             = r_v_src;
  assign v_amount          = r_v_amount;
  assign grant             = r_grant;
  assign done              = r_done;
  assign accepted          = r_accepted;
  assign remaining_amount  = r_rem;
  assign payment_complete  = r_loaded && (r_rem == 8'd0);
  assign line_disconnected = r_line_disc;

endmodule

// File: tb/tb_payment_verify_arbiter.sv
// Directed bench for payment_verify_arbiter: hand-computed expectations
// checked with immediate assertions after each clock edge.
module tb_payment_verify_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        bill_load;
  logic [7:0]  bill_value;
  logic [3:0]  req;
  logic [31:0] req_amount;
  logic        v_req;
  logic [1:0]  v_src;
  logic [7:0]  v_amount;
  logic        v_ack;
  logic        v_ok;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        accepted;
  logic [7:0]  remaining_amount;
  logic        payment_complete;
  logic        line_disconnected;

  int n_vec  = 0;
  int n_miss = 0;

  payment_verify_arbiter #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .bill_load         (bill_load),
    .bill_value        (bill_value),
    .req               (req),
    .req_amount        (req_amount),
    .v_req             (v_req),
    .v_src             (v_src),
    .v_amount          (v_amount),
    .v_ack             (v_ack),
    .v_ok              (v_ok),
    .grant             (grant),
    .done              (done),
    .accepted          (accepted),
    .remaining_amount  (remaining_amount),
    .payment_complete  (payment_complete),
    .line_disconnected (line_disconnected)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic load_bill(input logic [7:0] val);
    bill_load  = 1'b1;
    bill_value = val;
    tick();
    bill_load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    reset = 1'b0; bill_load = 1'b0; bill_value = 8'h00; req = 4'b0000;
    req_amount = 32'h0; v_ack = 1'b0; v_ok = 1'b0;
    tick(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_vreq", 32'(v_req), 32'h0);
    chk("rst_rem", 32'(remaining_amount), 32'h0);
    chk("rst_complete", 32'(payment_complete), 32'h0);
    chk("rst_line", 32'(line_disconnected), 32'h0);
    reset = 1'b1;

    // Single request, ack on first WAIT cycle.
    load_bill(8'h80);
    chk("t1_rem_loaded", 32'(remaining_amount), 32'h80);
    req = 4'b0001; req_amount = 32'h0000_0032;
    tick();
    chk("t1_grant_e0", 32'(grant), 32'h0);
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_vreq", 32'(v_req), 32'h1);
    chk("t1_vamt", 32'(v_amount), 32'h32);
    chk("t1_vsrc", 32'(v_src), 32'h0);
    v_ack = 1'b1; v_ok = 1'b1;
    tick();
    v_ack = 1'b0; req = 4'b0000;
    chk("t1_done_early", 32'(done), 32'h0);
    tick();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_acc", 32'(accepted), 32'h1);
    chk("t1_rem", 32'(remaining_amount), 32'h4E);
    chk("t1_grant_clr", 32'(grant), 32'h0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'h0);

    // Round-robin fairness from reset.
    do_reset();
    load_bill(8'hFF);
    req = 4'b1111; req_amount = 32'h0101_0101;
    for (int i = 0; i < 5; i++) begin
      tick(2);
      chk($sformatf("t2_grant%0d", i), 32'(grant), 32'(order[i]));
      v_ack = 1'b1; v_ok = 1'b1;
      tick();
      v_ack = 1'b0;
      tick();
      chk($sformatf("t2_done%0d", i), 32'(done), 32'(order[i]));
    end
    req = 4'b0000;
    chk("t2_rem", 32'(remaining_amount), 32'hFA);
    tick(2);

    // Verifier timeout.
    do_reset();
    load_bill(8'h50);
    req = 4'b0100; req_amount = 32'h0011_0000;
    tick(2);
    chk("t3_grant", 32'(grant), 32'h4);
    chk("t3_vsrc", 32'(v_src), 32'h2);
    chk("t3_vamt", 32'(v_amount), 32'h11);
    tick(15);
    chk("t3_line_early", 32'(line_disconnected), 32'h0);
    chk("t3_vreq_held", 32'(v_req), 32'h1);
    chk("t3_vamt_stable", 32'(v_amount), 32'h11);
    tick();
    req = 4'b0000;
    chk("t3_line", 32'(line_disconnected), 32'h1);
    chk("t3_done", 32'(done), 32'h4);
    chk("t3_acc", 32'(accepted), 32'h0);
    chk("t3_rem", 32'(remaining_amount), 32'h50);
    v_ack = 1'b1; v_ok = 1'b1;
    tick();
    v_ack = 1'b0;
    chk("t3_line_pulse", 32'(line_disconnected), 32'h0);
    chk("t3_stray_ack_done", 32'(done), 32'h0);
    chk("t3_stray_ack_rem", 32'(remaining_amount), 32'h50);

    // Rejection, then saturation to zero.
    do_reset();
    load_bill(8'h20);
    req = 4'b0010; req_amount = 32'h0000_5000;
    tick(2);
    chk("t4_grant_dd", 32'(grant), 32'h2);
    v_ack = 1'b1; v_ok = 1'b0;
    tick();
    v_ack = 1'b0; req = 4'b0000;
    tick();
    chk("t4_done_dd", 32'(done), 32'h2);
    chk("t4_acc_dd", 32'(accepted), 32'h0);
    chk("t4_rem_dd", 32'(remaining_amount), 32'h20);
    chk("t4_complete_dd", 32'(payment_complete), 32'h0);
    req = 4'b1000; req_amount = 32'h5000_0000;
    tick(2);
    chk("t4_grant_cur", 32'(grant), 32'h8);
    chk("t4_vamt_cur", 32'(v_amount), 32'h50);
    v_ack = 1'b1; v_ok = 1'b1;
    tick();
    v_ack = 1'b0; req = 4'b0000;
    tick();
    chk("t4_done_cur", 32'(done), 32'h8);
    chk("t4_acc_cur", 32'(accepted), 32'h1);
    chk("t4_rem_sat", 32'(remaining_amount), 32'h0);
    chk("t4_complete", 32'(payment_complete), 32'h1);
    req = 4'b0001; req_amount = 32'h0000_0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_nogrant%0d", i), 32'({grant, done, 3'b000, v_req}), 32'h0);
    end
    req = 4'b0000;

    // Reset while waiting on the verifier.
    do_reset();
    load_bill(8'h80);
    req = 4'b0010; req_amount = 32'h0000_1000;
    tick(2);
    chk("t5_grant", 32'(grant), 32'h2);
    tick();
    do_reset();
    req = 4'b0000;
    chk("t5_grant_rst", 32'(grant), 32'h0);
    chk("t5_vreq_rst", 32'(v_req), 32'h0);
    chk("t5_vsrc_rst", 32'(v_src), 32'h0);
    chk("t5_vamt_rst", 32'(v_amount), 32'h0);
    chk("t5_rem_rst", 32'(remaining_amount), 32'h0);
    chk("t5_done_rst", 32'(done), 32'h0);
    tick();
    chk("t5_done_after", 32'(done), 32'h0);
    load_bill(8'h40);
    req = 4'b1111; req_amount = 32'h0101_0101;
    tick(2);
    chk("t5_grant_bit0", 32'(grant), 32'h1);

    // Bill load and request in the same IDLE cycle.
    do_reset();
    req = 4'b0010; req_amount = 32'h0000_0400;
    bill_load = 1'b1; bill_value = 8'h10;
    tick();
    bill_load = 1'b0;
    chk("t6_rem", 32'(remaining_amount), 32'h10);
    chk("t6_grant_e0", 32'(grant), 32'h0);
    tick();
    chk("t6_grant_e1", 32'(grant), 32'h0);
    tick();
    chk("t6_grant", 32'(grant), 32'h2);
    v_ack = 1'b1; v_ok = 1'b1;
    tick();
    v_ack = 1'b0; req = 4'b0000;
    tick();
    chk("t6_done", 32'(done), 32'h2);
    chk("t6_rem_after", 32'(remaining_amount), 32'h0C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
